// File: rtl/pcm_frame_fifo.sv
// pcm_frame_fifo: converts I2S sample words to saturated signed PCM, buffers
// them in a first-word-fall-through FIFO with frame-boundary tags, and serves
// them on a valid/ready stream.
// Optional build macro PCM_DCBLOCK_EN inserts a first-order DC blocker (one
// extra pipeline stage between accept and push).
module pcm_frame_fifo #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned SHIFT     = 14,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned FRAME_LEN = 40,
   parameter int unsigned DC_K      = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [31:0]                in_data,
   input  logic                       vad_active,
   input  logic                       vad_gate,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       clr_overflow,
   output logic                       frame_irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned FW = $clog2(FRAME_LEN);
   localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
   localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FRAME_LEN < 2 || FRAME_LEN > 127 ||
       OUT_W < 2 || OUT_W > 31 || DC_K == 0) begin : g_param_check
      $error("pcm_frame_fifo: illegal parameter set");
   end

   logic                    accept;
   logic signed [31:0]      shifted;
   logic signed [OUT_W-1:0] conv;
   logic                    push_req;
   logic [OUT_W-1:0]        push_data;

   assign accept  = en & in_valid & (~vad_gate | vad_active);
   assign shifted = $signed(in_data) >>> SHIFT;

   // Saturate the shifted word into the signed OUT_W range
   always_comb begin
      conv = shifted[OUT_W-1:0];
      if (shifted > SAT_MAX)
         conv = SAT_MAX[OUT_W-1:0];
      else if (shifted < SAT_MIN)
         conv = SAT_MIN[OUT_W-1:0];
   end

`ifdef PCM_DCBLOCK_EN
   localparam int unsigned IW = OUT_W + DC_K + 2;
   localparam logic signed [IW-1:0] F_MAX = {{(DC_K + 3){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [IW-1:0] F_MIN = {{(DC_K + 3){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic signed [OUT_W-1:0] x_prev, y_prev, filt;
   logic signed [IW-1:0]    xe, xpe, ype, sum;
   logic                    push_req_r;
   logic [OUT_W-1:0]        push_data_r;

   assign xe  = {{(DC_K + 2){conv[OUT_W-1]}}, conv};
   assign xpe = {{(DC_K + 2){x_prev[OUT_W-1]}}, x_prev};
   assign ype = {{(DC_K + 2){y_prev[OUT_W-1]}}, y_prev};
   assign sum = xe - xpe + ype - (ype >>> DC_K);

   // Saturate the wide filter result back to OUT_W
   always_comb begin
      filt = sum[OUT_W-1:0];
      if (sum > F_MAX)
         filt = F_MAX[OUT_W-1:0];
      else if (sum < F_MIN)
         filt = F_MIN[OUT_W-1:0];
   end

   // Filter history advances on every accept; the result is pushed next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_prev      <= '0;
         y_prev      <= '0;
         push_req_r  <= 1'b0;
         push_data_r <= '0;
      end else if (flush) begin
         x_prev      <= '0;
         y_prev      <= '0;
         push_req_r  <= 1'b0;
         push_data_r <= '0;
      end else begin
         push_req_r <= accept;
         if (accept) begin
            x_prev      <= conv;
            y_prev      <= filt;
            push_data_r <= filt;
         end
      end
   end

   assign push_req  = push_req_r;
   assign push_data = push_data_r;
`else
   assign push_req  = accept;
   assign push_data = conv;
`endif

   logic [OUT_W:0]   mem [DEPTH];
   logic [LW-1:0]    wr_ptr, rd_ptr;
   logic [FW-1:0]    frame_cnt;
   logic             full, pop, push_ok, drop, last_w;
   logic [OUT_W:0]   head;

   assign level     = wr_ptr - rd_ptr;
   assign out_valid = (level != '0);
   assign full      = (level == LW'(DEPTH));
   assign pop       = out_valid & out_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle
   assign push_ok   = push_req & (~full | pop);
   assign drop      = push_req & full & ~pop;
   assign last_w    = (frame_cnt == FW'(FRAME_LEN - 1));
   assign head      = mem[rd_ptr[AW-1:0]];
   assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
   assign out_last  = out_valid & head[OUT_W];

   // Pointer, frame counter and frame interrupt update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_cnt <= '0;
         frame_irq <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_cnt <= '0;
         frame_irq <= 1'b0;
      end else begin
         frame_irq <= push_ok & last_w;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok) begin
            wr_ptr    <= wr_ptr + 1'b1;
            frame_cnt <= last_w ? '0 : frame_cnt + 1'b1;
         end
      end
   end

   // Storage write: sample plus frame-last tag
   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         mem[wr_ptr[AW-1:0]] <= {last_w, push_data};
   end

   // Sticky overflow; a new drop takes priority over clearing
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (drop && !flush)
         overflow <= 1'b1;
      else if (clr_overflow)
         overflow <= 1'b0;
   end

endmodule

// File: tb/tb_pcm_frame_fifo.sv
// Self-checking bench for pcm_frame_fifo (default build) against a queue-based
// reference model.
module tb_pcm_frame_fifo;

   localparam int DEPTH = 16;
   localparam int SHIFT = 14;
   localparam int OUT_W = 16;
   localparam int FL    = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, flush, in_valid, vad_active, vad_gate, out_ready, clr_overflow;
   logic [31:0] in_data;
   logic [15:0] out_data;
   logic        out_last, out_valid, overflow, frame_irq;
   logic [4:0]  level;

   pcm_frame_fifo #(
      .DEPTH(DEPTH), .SHIFT(SHIFT), .OUT_W(OUT_W), .FRAME_LEN(FL), .DC_K(6)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
      .in_data(in_data), .vad_active(vad_active), .vad_gate(vad_gate),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
      .out_ready(out_ready), .level(level), .overflow(overflow),
      .clr_overflow(clr_overflow), .frame_irq(frame_irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [16:0] q[$];
   int          m_cnt;
   bit          m_ov;
   bit          m_irq;

   // Phase bookkeeping from observed DUT behaviour
   int pop_cnt;
   int last_idx[$];
   int irq_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_conv(input logic [31:0] w);
      longint v, d, r;
      logic [15:0] res;
      v = longint'($signed(w));
      d = longint'(1) << SHIFT;
      if (v >= 0) r = v / d;
      else        r = -((-v + d - 1) / d);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      res = r[15:0];
      return res;
   endfunction

   task automatic compare();
      logic [16:0] h;
      check("valid", out_valid, q.size() != 0);
      check("level", level, q.size());
      check("overflow", overflow, m_ov);
      check("frame_irq", frame_irq, m_irq);
      if (q.size() != 0) begin
         h = q[0];
         check("data", out_data, h[15:0]);
         check("last", out_last, h[16]);
      end
      if (frame_irq) irq_seen++;
   endtask

   // One clock: drive inputs at negedge, advance model, check at next negedge
   task automatic cycle(input bit e, input bit iv, input logic [31:0] d, input bit va,
                        input bit vg, input bit rdy, input bit fl, input bit clr);
      bit acc, pop, ov_set, dut_pop_last;
      dut_pop_last = out_valid & out_last & rdy & !fl;
      if (out_valid && rdy && !fl) begin
         pop_cnt++;
         if (dut_pop_last) last_idx.push_back(pop_cnt);
      end
      en = e; in_valid = iv; in_data = d; vad_active = va; vad_gate = vg;
      out_ready = rdy; flush = fl; clr_overflow = clr;
      acc    = e & iv & (!vg | va);
      pop    = (q.size() != 0) && rdy;
      ov_set = 1'b0;
      if (fl) begin
         q.delete();
         m_cnt = 0;
         m_irq = 1'b0;
      end else begin
         m_irq = 1'b0;
         if (pop) void'(q.pop_front());
         if (acc) begin
            if (q.size() < DEPTH) begin
               q.push_back({m_cnt == FL - 1, ref_conv(d)});
               if (m_cnt == FL - 1) begin
                  m_irq = 1'b1;
                  m_cnt = 0;
               end else begin
                  m_cnt++;
               end
            end else begin
               ov_set = 1'b1;
            end
         end
      end
      if (ov_set)   m_ov = 1'b1;
      else if (clr) m_ov = 1'b0;
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 32'h0, 0, 0, rdy, 0, 0);
   endtask

   task automatic push1(input logic [31:0] d, input bit rdy);
      cycle(1, 1, d, 0, 0, rdy, 0, 0);
   endtask

   task automatic do_flush();
      cycle(1, 0, 32'h0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      rst = 1'b1; en = 0; flush = 0; in_valid = 0; in_data = '0;
      vad_active = 0; vad_gate = 0; out_ready = 0; clr_overflow = 0;
      m_cnt = 0; m_ov = 0; m_irq = 0; pop_cnt = 0; irq_seen = 0;
      repeat (3) @(negedge clk);
      compare();
      rst = 1'b0;
      @(negedge clk);
      compare();

      // Conversion and saturation
      push1(32'h0001_0000, 0);
      push1(32'hFFFF_0000, 0);
      push1(32'h7FFF_FFFF, 0);
      check("p1_level3", level, 3);
      check("p1_s0", out_data, 16'h0004);
      idle(1, 1);
      check("p1_s1", out_data, 16'hFFFC);
      idle(1, 1);
      check("p1_s2", out_data, 16'h7FFF);
      idle(1, 1);
      check("p1_level0", level, 0);

      // Overflow with consumer stalled
      do_flush();
      for (int i = 0; i < 40; i++) push1($urandom, 0);
      check("p2_level", level, 16);
      check("p2_ov", overflow, 1);
      cycle(1, 0, 32'h0, 0, 0, 0, 0, 1);
      check("p2_clr", overflow, 0);

      // Full with simultaneous pop and push
      push1(32'h0002_0000, 1);
      check("p3_level", level, 16);
      check("p3_ov", overflow, 0);
      idle(1, 20);

      // Frame tagging over two frames
      do_flush();
      pop_cnt = 0; last_idx.delete(); irq_seen = 0;
      for (int i = 0; i < 80; i++) push1($urandom, 1);
      idle(1, 2);
      check("p4_nlast", last_idx.size(), 2);
      if (last_idx.size() == 2) begin
         check("p4_last0", last_idx[0], 40);
         check("p4_last1", last_idx[1], 80);
      end
      check("p4_irq", irq_seen, 2);

      // VAD gating
      for (int i = 0; i < 40; i++)
         cycle(1, 1, $urandom, ((i / 5) % 2) == 0, 1, $urandom_range(0, 1), 0, 0);
      idle(1, 20);

      // Flush at level 7, frame count 12, with overflow set
      do_flush();
      for (int i = 0; i < 20; i++) push1($urandom, 0);
      cycle(1, 0, 32'h0, 0, 0, 0, 0, 1);
      do_flush();
      for (int i = 0; i < 17; i++) push1($urandom, 0);
      idle(1, 10);
      do_flush();
      for (int i = 0; i < 12; i++) push1($urandom, 0);
      idle(1, 5);
      check("p6_level7", level, 7);
      do_flush();
      check("p6_level0", level, 0);
      check("p6_valid", out_valid, 0);
      pop_cnt = 0; last_idx.delete();
      for (int i = 0; i < 40; i++) push1($urandom, 1);
      idle(1, 2);
      check("p6_frame0", last_idx.size(), 1);

      // Randomized traffic
      for (int blk = 0; blk < 50; blk++) begin
         int rdy_pct;
         rdy_pct = $urandom_range(0, 100);
         for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 5))
               0:       d = 32'h8000_0000;
               1:       d = 32'h7FFF_FFFF;
               2:       d = 32'h1FFF_C000;
               3:       d = 32'hE000_0000;
               default: d = $urandom;
            endcase
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1), d,
                  $urandom_range(0, 1), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 19) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pcm_frame_fifo.md
Name: pcm_frame_fifo

Overview:
- Consumes the 32-bit sample word and one-cycle `done` strobe produced by the I2S receiver.
- Converts each accepted word to a saturated OUT_W-bit signed PCM sample and optionally gates capture on the receiver's VAD flag.
- Buffers samples in a first-word-fall-through FIFO, tagging frame boundaries every FRAME_LEN samples.
- Exposes a valid/ready stream for the DMA controller that moves frames to the inference memory.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- SHIFT, 14, arithmetic right shift applied to the 32-bit input word before saturation.
- OUT_W, 16, output sample width in bits.
- FRAME_LEN, 40, accepted samples per frame; range 2..127.
- DC_K, 6, DC-blocker pole shift; used only with PCM_DCBLOCK_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; read side operates regardless.
- flush  input  1  synchronous clear of FIFO, frame counter and filter state.
- in_valid  input  1  sample strobe (I2S `done`).
- in_data  input  32  signed sample word (I2S `data`).
- vad_active  input  1  voice-activity flag from I2S receiver.
- vad_gate  input  1  1 = accept samples only while vad_active = 1.
- out_data  output  OUT_W  head-of-FIFO sample.
- out_last  output  1  head sample is the last of a frame.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head this cycle.
- level  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: an accepted sample was dropped because the FIFO was full.
- clr_overflow  input  1  clears overflow.
- frame_irq  output  1  one-cycle pulse when a frame's last sample is written.

Behaviour:
- Reset: all outputs 0; FIFO empty; frame counter 0; filter state 0.
- accept = en & in_valid & (~vad_gate | vad_active); evaluated every cycle, no strobe-width assumption.
- Conversion:
  - y = $signed(in_data) >>> SHIFT.
  - If y > 2^(OUT_W-1)-1, clamp to 2^(OUT_W-1)-1.
  - If y < -2^(OUT_W-1), clamp to -2^(OUT_W-1).
  - Otherwise keep the low OUT_W bits.
  - Purely combinational path into the write port.
- Write timing:
  - The sample is written at the edge where accept=1 (latency 1 cycle without the option).
  - out_valid and level update after that edge.
- Push rule: the push succeeds if level<DEPTH, or if a pop occurs the same cycle (full with simultaneous pop accepts the push; level unchanged).
- Dropped sample:
  - overflow <= 1.
  - Sample discarded; frame counter does not advance; frame_irq not pulsed.
- Pop:
  - out_valid & out_ready advances the read pointer.
  - out_ready while empty has no effect.
  - out_data/out_last are held stable while out_valid=1 and out_ready=0.
- Frame counter:
  - Increments on each successful push.
  - The sample pushed when count==FRAME_LEN-1 is stored with last=1; the counter wraps to 0.
  - frame_irq=1 in the following cycle only.
- en low: no pushes; frame counter and filter state hold; pops continue.
- flush:
  - Next edge: level=0, pointers 0, frame counter 0, filter state 0, out_valid=0.
  - A coincident push or pop is ignored; overflow is retained.
- Overflow clearing: clr_overflow clears overflow; set wins over clear in the same cycle.
- Pointers: wrap modulo DEPTH; level is computed from the pointer difference with an extra wrap bit, so full (level=DEPTH) and empty (level=0) are distinct.

Optional Feature:
- Macro: PCM_DCBLOCK_EN.
- Defined:
  - A first-order DC blocker is inserted after conversion: s = x - x_prev + y_prev - (y_prev >>> DC_K).
  - Internal width OUT_W+DC_K+2; result saturated to OUT_W.
  - x_prev and y_prev update only on accept (including dropped samples).
  - Adds one register stage: the push occurs one cycle after accept.
  - Push/overflow/frame rules apply at that delayed cycle.
- Undefined: no filter; single-cycle path as above.

Test Plan:
- Reset, then 3 accepts with in_data=32'h0001_0000, 32'hFFFF_0000, 32'h7FFF_FFFF (SHIFT=14) -> out_data 16'h0004, 16'hFFFC, 16'h7FFF (saturated); level 3 then 0 with out_ready=1.
- 40 accepts, out_ready=0 -> 16th write fills FIFO, writes 17..40 dropped, overflow=1, frame counter=16; clr_overflow -> overflow=0.
- DEPTH=16 full and out_ready=1 with accept in the same cycle -> push accepted, level stays 16, overflow stays 0.
- 80 accepts with out_ready=1 -> out_last=1 exactly on samples 40 and 80; frame_irq pulses twice, one cycle after each write.
- vad_gate=1, vad_active toggling every 5 strobes -> only strobes with vad_active=1 are stored; frame counter counts only those.
- flush while level=7 and frame count 12 -> next cycle level=0, out_valid=0, next accepted sample counts as frame index 0; overflow unchanged.
